// File: rtl/sel_skid_stage.sv
// sel_skid_stage
// Registered source-select stage with a two-entry skid buffer. Each accepted
// beat captures one of three sources (foo/bar/default decode of sel) plus the
// selector itself. in_ready is decoded from state only, so out_ready never
// reaches in_ready combinationally.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   rst          synchronous active-high reset
//   sel          source select: 0 = in_a, 1 = in_b, 2/3 = in_c
//   in_a/b/c     candidate sources, WIDTH bits
//   in_valid     upstream beat present
//   in_ready     stage can accept a beat
//   out_data     selected data of the head beat
//   out_sel      sel value captured with the head beat
//   out_valid    head beat present
//   out_ready    downstream accepts the head beat
//   stall_count  saturating count of cycles with out_valid && !out_ready
//                (only when SEL_SKID_STALL_CNT_EN is defined)
//
// Optional feature macro: SEL_SKID_STALL_CNT_EN

module sel_skid_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEL_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] main_data;
  logic [1:0]       main_sel;
  logic [WIDTH-1:0] skid_data;
  logic [1:0]       skid_sel;

  logic [WIDTH-1:0] mux_data;
  logic             accept;
  logic             pop;

  // Source decode; both 2 and 3 fall through to the default source.
  always_comb begin
    mux_data = in_c;
    case (sel)
      2'd0:    mux_data = in_a;
      2'd1:    mux_data = in_b;
      default: mux_data = in_c;
    endcase
  end

  // Handshake outputs come straight from the occupancy state.
  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    out_data  = main_data;
    out_sel   = main_sel;
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Occupancy next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) state_next = ONE;
      end
      ONE: begin
        if (accept && !pop)      state_next = TWO;
        else if (pop && !accept) state_next = EMPTY;
      end
      TWO: begin
        if (pop) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Storage update. With a simultaneous accept and pop in ONE the new beat
  // replaces the head directly; the skid entry is only used when the head
  // is stuck, and drains into the head on the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= mux_data;
            main_sel  <= sel;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= mux_data;
            main_sel  <= sel;
          end else if (accept) begin
            skid_data <= mux_data;
            skid_sel  <= sel;
          end
        end
        TWO: begin
          if (pop) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEL_SKID_STALL_CNT_EN
  // Counts cycles the head beat waits on downstream; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
